capture_sequencer: RTL and testbench

//  Sequences one ADC capture: arm, optional wait-for-inactive, trigger detect, programmable

---
 rtl/capture_sequencer.sv | 135 +++++++++++++
 tb/tb_capture_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Counted, abortable ADC capture sequencer: arm, optional wait-for-inactive, trigger,
// post-trigger delay, then gates capture_go_o for exactly samples_l accepted samples.
module capture_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm_i,
    input  logic                   abort_i,
    input  logic                   trigger_i,
    input  logic                   trigger_level_i,
    input  logic                   trigger_wait_i,
    input  logic                   trigger_now_i,
    input  logic [DELAY_WIDTH-1:0] delay_i,
    input  logic [CNT_WIDTH-1:0]   samples_i,
    input  logic                   sample_valid_i,
    output logic                   capture_go_o,
    output logic                   armed_o,
    output logic                   triggered_o,
    output logic                   done_o,
    output logic [CNT_WIDTH-1:0]   sample_count_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAITINACT = 3'd1,
        S_ARMED     = 3'd2,
        S_DELAY     = 3'd3,
        S_CAPTURE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   arm_q;
    logic                   level_q, level_d;
    logic [DELAY_WIDTH-1:0] delay_l_q, delay_l_d;
    logic [CNT_WIDTH-1:0]   samples_l_q, samples_l_d;
    logic [DELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic arm_edge;
    logic trig_act;

    assign arm_edge = arm_i & ~arm_q;
    assign trig_act = (trigger_i == level_q) | trigger_now_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            level_q     <= 1'b0;
            delay_l_q   <= '0;
            samples_l_q <= '0;
            delay_cnt_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_i;
            level_q     <= level_d;
            delay_l_q   <= delay_l_d;
            samples_l_q <= samples_l_d;
            delay_cnt_q <= delay_cnt_d;
            count_q     <= count_d;
        end
    end

    // sample_valid_i is a one-cycle "writer accepted a sample" pulse; it only counts
    // while capture_go_o is high, and the writer never waits on us (no back-pressure).
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        delay_l_d   = delay_l_q;
        samples_l_d = samples_l_q;
        delay_cnt_d = delay_cnt_q;
        count_d     = count_q;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_edge && (samples_i != '0)) begin
                        level_d     = trigger_level_i;
                        delay_l_d   = delay_i;
                        samples_l_d = samples_i;
                        count_d     = '0;
                        state_d     = trigger_wait_i ? S_WAITINACT : S_ARMED;
                    end
                end
                S_WAITINACT, S_ARMED: begin
                    // trigger_now_i fires from either state; a real trigger must first
                    // be seen inactive while waiting.
                    if (trigger_now_i || (state_q == S_ARMED && trig_act)) begin
                        if (delay_l_q == '0) begin
                            state_d = S_CAPTURE;
                        end else begin
                            state_d     = S_DELAY;
                            delay_cnt_d = delay_l_q - DELAY_WIDTH'(1);
                        end
                    end else if (state_q == S_WAITINACT && (trigger_i != level_q)) begin
                        state_d = S_ARMED;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt_q == '0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DELAY_WIDTH'(1);
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid_i) begin
                        count_d = count_q + CNT_WIDTH'(1);
                        if (count_q == samples_l_q - CNT_WIDTH'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign capture_go_o   = (state_q == S_CAPTURE);
    assign armed_o        = (state_q == S_WAITINACT) || (state_q == S_ARMED);
    assign triggered_o    = (state_q == S_DELAY) || (state_q == S_CAPTURE) || (state_q == S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign sample_count_o = count_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a flag-based behavioural model.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm_i, abort_i, trigger_i, trigger_level_i, trigger_wait_i, trigger_now_i;
    logic [15:0] delay_i;
    logic [31:0] samples_i;
    logic        sample_valid_i;
    logic        capture_go_o, armed_o, triggered_o, done_o;
    logic [31:0] sample_count_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_sequencer dut (
        .clk             (clk),
        .reset           (rst),
        .arm_i           (arm_i),
        .abort_i         (abort_i),
        .trigger_i       (trigger_i),
        .trigger_level_i (trigger_level_i),
        .trigger_wait_i  (trigger_wait_i),
        .trigger_now_i   (trigger_now_i),
        .delay_i         (delay_i),
        .samples_i       (samples_i),
        .sample_valid_i  (sample_valid_i),
        .capture_go_o    (capture_go_o),
        .armed_o         (armed_o),
        .triggered_o     (triggered_o),
        .done_o          (done_o),
        .sample_count_o  (sample_count_o),
        .state_o         (state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_wait, m_armed, m_cap, m_done;
    int          m_left;          // delay cycles still to spend before capture
    logic [31:0] m_count, m_samples;
    logic [15:0] m_delay;
    logic        m_level, m_arm_prev;
    logic        e_arm, e_act;

    task automatic m_fire();
        m_wait  = 0;
        m_armed = 0;
        if (m_delay == 0) m_cap = 1;
        else m_left = int'(m_delay);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait = 0; m_armed = 0; m_cap = 0; m_done = 0; m_left = 0;
            m_count = 0; m_samples = 0; m_delay = 0; m_level = 0; m_arm_prev = 0;
        end else begin
            e_arm = arm_i && !m_arm_prev;
            m_arm_prev = arm_i;
            e_act = (trigger_i == m_level) || trigger_now_i;
            if (abort_i) begin
                m_wait = 0; m_armed = 0; m_cap = 0; m_done = 0; m_left = 0;
            end else if (m_wait) begin
                if (trigger_now_i) m_fire();
                else if (trigger_i != m_level) begin m_wait = 0; m_armed = 1; end
            end else if (m_armed) begin
                if (e_act) m_fire();
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_cap = 1;
            end else if (m_cap) begin
                if (sample_valid_i) begin
                    m_count++;
                    if (m_count == m_samples) begin m_cap = 0; m_done = 1; end
                end
            end else if (e_arm && samples_i != 0) begin
                m_level = trigger_level_i; m_delay = delay_i; m_samples = samples_i;
                m_count = 0; m_done = 0;
                if (trigger_wait_i) m_wait = 1; else m_armed = 1;
            end
        end
    end

    function automatic logic [2:0] m_state();
        if (m_wait)     return 3'd1;
        if (m_armed)    return 3'd2;
        if (m_left > 0) return 3'd3;
        if (m_cap)      return 3'd4;
        if (m_done)     return 3'd5;
        return 3'd0;
    endfunction

    always @(negedge clk) begin
        chk("go",        32'(capture_go_o), 32'(m_cap));
        chk("armed",     32'(armed_o),      32'(m_wait || m_armed));
        chk("triggered", 32'(triggered_o),  32'(m_left > 0 || m_cap || m_done));
        chk("done",      32'(done_o),       32'(m_done));
        chk("count",     sample_count_o,    m_count);
        chk("state",     32'(state_o),      32'(m_state()));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_cfg(input logic lvl, input logic wt, input logic [15:0] dly,
                           input logic [31:0] smp);
        trigger_level_i = lvl; trigger_wait_i = wt; delay_i = dly; samples_i = smp;
        arm_i = 1'b0;
        tick();
        arm_i = 1'b1;
        tick();
    endtask

    task automatic finish_capture(output int go_cycles);
        int n = 0;
        go_cycles = 0;
        sample_valid_i = 1'b1;
        while (!done_o && n < 40) begin
            if (capture_go_o) go_cycles++;
            tick();
            n++;
        end
        sample_valid_i = 1'b0;
    endtask

    initial begin
        int n, gc;
        logic v;
        rst = 1'b1;
        arm_i = 0; abort_i = 0; trigger_i = 0; trigger_level_i = 0; trigger_wait_i = 0;
        trigger_now_i = 0; delay_i = 0; samples_i = 0; sample_valid_i = 0;
        tick(); tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_count", sample_count_o, 0);
        rst = 1'b0;
        tick();

        // 1: delay 0, four samples back to back
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd4);
        chk("t1_armed_state", 32'(state_o), 2);
        trigger_i = 1'b1;
        tick();
        chk("t1_go_next", 32'(capture_go_o), 1);
        finish_capture(gc);
        chk("t1_go_cycles", 32'(gc), 4);
        chk("t1_done", 32'(done_o), 1);
        chk("t1_count", sample_count_o, 4);

        // 2: wait-for-inactive with trigger already active at arm
        arm_cfg(1'b1, 1'b1, 16'd0, 32'd2);
        tick(); tick(); tick();
        chk("t2_waitinact", 32'(state_o), 1);
        chk("t2_armed_o", 32'(armed_o), 1);
        trigger_i = 1'b0;
        tick();
        chk("t2_armed_state", 32'(state_o), 2);
        chk("t2_no_go", 32'(capture_go_o), 0);
        trigger_i = 1'b1;
        tick();
        chk("t2_go", 32'(capture_go_o), 1);
        finish_capture(gc);
        chk("t2_count", sample_count_o, 2);

        // 3: delay 10, samples accepted every other cycle
        trigger_i = 1'b0;
        arm_cfg(1'b1, 1'b0, 16'd10, 32'd3);
        trigger_i = 1'b1;
        tick();
        chk("t3_delay_state", 32'(state_o), 3);
        n = 0;
        while (!capture_go_o && n < 30) begin tick(); n++; end
        chk("t3_delay_len", 32'(n), 10);
        n = 0; gc = 0; v = 1'b0;
        while (capture_go_o && n < 30) begin
            gc++; sample_valid_i = v; v = ~v; tick(); n++;
        end
        sample_valid_i = 1'b0;
        chk("t3_go_cycles", 32'(gc), 6);
        chk("t3_count", sample_count_o, 3);
        chk("t3_done", 32'(done_o), 1);

        // 4: abort after the second accepted sample
        trigger_i = 1'b0;
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd8);
        trigger_i = 1'b1; sample_valid_i = 1'b1;
        tick(); tick(); tick();
        chk("t4_count_pre", sample_count_o, 2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0; sample_valid_i = 1'b0; trigger_i = 1'b0;
        chk("t4_idle", 32'(state_o), 0);
        chk("t4_go", 32'(capture_go_o), 0);
        chk("t4_done", 32'(done_o), 0);
        chk("t4_count_held", sample_count_o, 2);
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd8);
        chk("t4_rearm_count", sample_count_o, 0);
        abort_i = 1'b1; tick(); abort_i = 1'b0;

        // 5: zero-length arm ignored; trigger_now overrides mismatched level
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd0);
        chk("t5_zero_idle", 32'(state_o), 0);
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd2);
        chk("t5_armed", 32'(state_o), 2);
        trigger_now_i = 1'b1;
        tick();
        trigger_now_i = 1'b0;
        chk("t5_now_go", 32'(capture_go_o), 1);
        finish_capture(gc);
        chk("t5_done", 32'(done_o), 1);

        // 6: asynchronous reset in the middle of a capture
        arm_cfg(1'b1, 1'b0, 16'd0, 32'd5);
        trigger_i = 1'b1; sample_valid_i = 1'b1;
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("t6_go", 32'(capture_go_o), 0);
        chk("t6_state", 32'(state_o), 0);
        chk("t6_count", sample_count_o, 0);
        chk("t6_triggered", 32'(triggered_o), 0);
        trigger_i = 1'b0; sample_valid_i = 1'b0;
        tick();
        arm_i = 1'b0;
        rst = 1'b0;
        tick();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) arm_i = ~arm_i;
            abort_i         = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) trigger_i = ~trigger_i;
            trigger_now_i   = ($urandom_range(0, 31) == 0);
            trigger_level_i = 1'($urandom_range(0, 1));
            trigger_wait_i  = 1'($urandom_range(0, 1));
            delay_i         = 16'($urandom_range(0, 4));
            samples_i       = 32'($urandom_range(0, 6));
            sample_valid_i  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
